// File: rtl/flash_sequencer.sv
// Pattern controller for the flash-1 / flash-2 shifter pair: prescaled sweep
// patterns per mode, with a return-to-home phase on every mode change.
module flash_sequencer #(
  parameter int unsigned TICK_DIV = 25_000_000,
  parameter int unsigned CNT_W    = 25
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       mode_next,
  output logic       f1_shift_left,
  output logic       f1_shift_right,
  output logic       f2_shift_left,
  output logic       f2_shift_right,
  output logic [1:0] mode,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOME = 2'd2
  } state_t;

  typedef enum logic {
    DIR_OUT = 1'b0,
    DIR_IN  = 1'b1
  } dir_t;

  state_t           state, state_n;
  dir_t             dir, dir_n;
  logic [1:0]       mode_n;
  logic [1:0]       pos1, pos1_n;
  logic [1:0]       pos2, pos2_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             f1l_n, f1r_n, f2l_n, f2r_n;
  logic             tick;
  logic             f1_act, f2_act;
  logic [1:0]       lead;

  // mode bit 0 enables flash-1, bit 1 enables flash-2
  assign f1_act = mode[0];
  assign f2_act = mode[1];
  // both active shifters move in lockstep, so one position decides direction
  assign lead   = f1_act ? pos1 : pos2;
  assign tick   = (state == RUN) && (cnt == CNT_W'(TICK_DIV - 1));
  assign busy   = (state == HOME);

  // Register all state and the pulse outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= IDLE;
      dir            <= DIR_OUT;
      mode           <= '0;
      pos1           <= '0;
      pos2           <= '0;
      cnt            <= '0;
      f1_shift_left  <= 1'b0;
      f1_shift_right <= 1'b0;
      f2_shift_left  <= 1'b0;
      f2_shift_right <= 1'b0;
    end else begin
      state          <= state_n;
      dir            <= dir_n;
      mode           <= mode_n;
      pos1           <= pos1_n;
      pos2           <= pos2_n;
      cnt            <= cnt_n;
      f1_shift_left  <= f1l_n;
      f1_shift_right <= f1r_n;
      f2_shift_left  <= f2l_n;
      f2_shift_right <= f2r_n;
    end
  end

  // Next-state, prescaler, position and pulse decisions
  always_comb begin
    state_n = state;
    dir_n   = dir;
    mode_n  = mode;
    pos1_n  = pos1;
    pos2_n  = pos2;
    cnt_n   = '0;
    f1l_n   = 1'b0;
    f1r_n   = 1'b0;
    f2l_n   = 1'b0;
    f2r_n   = 1'b0;

    // The first homing pulse is registered on the mode_next edge itself so
    // that return pulses occupy the cycles right after the request.
    case (state)
      IDLE: begin
        if (mode_next) begin
          state_n = HOME;
          if (pos1 != 2'd0) begin f1l_n = 1'b1; pos1_n = pos1 - 2'd1; end
          if (pos2 != 2'd0) begin f2r_n = 1'b1; pos2_n = pos2 - 2'd1; end
        end
      end

      RUN: begin
        if (mode_next) begin
          state_n = HOME;
          if (pos1 != 2'd0) begin f1l_n = 1'b1; pos1_n = pos1 - 2'd1; end
          if (pos2 != 2'd0) begin f2r_n = 1'b1; pos2_n = pos2 - 2'd1; end
        end else if (tick) begin
          if (dir == DIR_OUT) begin
            if (f1_act) begin f1r_n = 1'b1; pos1_n = pos1 + 2'd1; end
            if (f2_act) begin f2l_n = 1'b1; pos2_n = pos2 + 2'd1; end
            if (lead == 2'd2) dir_n = DIR_IN;
          end else begin
            if (f1_act) begin f1l_n = 1'b1; pos1_n = pos1 - 2'd1; end
            if (f2_act) begin f2r_n = 1'b1; pos2_n = pos2 - 2'd1; end
            if (lead == 2'd1) dir_n = DIR_OUT;
          end
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end

      HOME: begin
        if ((pos1 == 2'd0) && (pos2 == 2'd0)) begin
          mode_n  = mode + 2'd1;
          dir_n   = DIR_OUT;
          state_n = (mode == 2'd3) ? IDLE : RUN;
        end else begin
          if (pos1 != 2'd0) begin f1l_n = 1'b1; pos1_n = pos1 - 2'd1; end
          if (pos2 != 2'd0) begin f2r_n = 1'b1; pos2_n = pos2 - 2'd1; end
        end
      end

      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_flash_sequencer.sv
// Scoreboard bench for flash_sequencer with TICK_DIV = 4.
module tb_flash_sequencer;

  localparam int unsigned TD = 4;
  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_HOME = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       mode_next = 1'b0;
  logic       f1_shift_left, f1_shift_right, f2_shift_left, f2_shift_right;
  logic [1:0] mode;
  logic       busy;

  int n_vec = 0;
  int n_err = 0;

  // expected {f1l, f1r, f2l, f2r, mode[1:0], busy} after each edge
  logic [6:0] exp_q[$];

  // reference model in terms of shifter values
  int  m_state, m_ph, s1, s2;
  int  m_mode;
  bit  m_out;

  // shifter models driven by the DUT pulses
  int sh1, sh2;

  always #5 clk = ~clk;

  flash_sequencer #(.TICK_DIV(TD), .CNT_W(3)) dut (
    .clk           (clk),
    .reset         (reset),
    .mode_next     (mode_next),
    .f1_shift_left (f1_shift_left),
    .f1_shift_right(f1_shift_right),
    .f2_shift_left (f2_shift_left),
    .f2_shift_right(f2_shift_right),
    .mode          (mode),
    .busy          (busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, want, $time);
    end
  endtask

  function automatic logic [6:0] obs();
    return {f1_shift_left, f1_shift_right, f2_shift_left, f2_shift_right, mode, busy};
  endfunction

  task automatic model_reset();
    m_state = M_IDLE; m_ph = 0; s1 = 32; s2 = 32; m_mode = 0; m_out = 1'b1;
    sh1 = 32; sh2 = 32;
    exp_q.delete();
  endtask

  task automatic go_home(inout bit f1l, inout bit f2r);
    m_state = M_HOME;
    m_ph = 0;
    if (s1 != 32) begin f1l = 1'b1; s1 = s1 / 2; end
    if (s2 != 32) begin f2r = 1'b1; s2 = s2 * 2; end
  endtask

  // advance the model across one clock edge and queue the expected outputs
  task automatic model_edge(input bit mn);
    bit f1l, f1r, f2l, f2r, a1, a2;
    logic [1:0] mm;
    f1l = 0; f1r = 0; f2l = 0; f2r = 0;
    a1 = (m_mode == 1) || (m_mode == 3);
    a2 = (m_mode == 2) || (m_mode == 3);
    if (m_state == M_IDLE) begin
      if (mn) go_home(f1l, f2r);
    end else if (m_state == M_RUN) begin
      if (mn) go_home(f1l, f2r);
      else if (m_ph == TD - 1) begin
        m_ph = 0;
        if (m_out) begin
          if (a1) begin f1r = 1; s1 = s1 * 2; end
          if (a2) begin f2l = 1; s2 = s2 / 2; end
          if (a1 ? (s1 == 256) : (s2 == 4)) m_out = 1'b0;
        end else begin
          if (a1) begin f1l = 1; s1 = s1 / 2; end
          if (a2) begin f2r = 1; s2 = s2 * 2; end
          if (a1 ? (s1 == 32) : (s2 == 32)) m_out = 1'b1;
        end
      end else m_ph++;
    end else begin
      if (s1 == 32 && s2 == 32) begin
        m_mode  = (m_mode + 1) % 4;
        m_out   = 1'b1;
        m_ph    = 0;
        m_state = (m_mode == 0) ? M_IDLE : M_RUN;
      end else go_home(f1l, f2r);
    end
    mm = 2'(m_mode);
    exp_q.push_back({f1l, f1r, f2l, f2r, mm, (m_state == M_HOME)});
  endtask

  // one clock: drive, predict, then compare against the scoreboard
  task automatic cyc(input bit mn);
    logic [6:0] e;
    mode_next = mn;
    model_edge(mn);
    @(posedge clk);
    #1;
    mode_next = 1'b0;
    if (exp_q.size() == 0) check("sb_empty", 1, 0);
    else begin
      e = exp_q.pop_front();
      check("cyc", 32'(obs()), 32'(e));
    end
    if (f1_shift_right && sh1 < 256) sh1 = sh1 * 2;
    if (f1_shift_left  && sh1 > 32)  sh1 = sh1 / 2;
    if (f2_shift_left  && sh2 > 4)   sh2 = sh2 / 2;
    if (f2_shift_right && sh2 < 32)  sh2 = sh2 * 2;
  endtask

  initial begin
    bit ok;
    int mx, mn2, npulse;

    // reset state
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst", 32'(obs()), 0);
    reset = 1'b1;
    repeat (3) cyc(0);

    // IDLE -> mode 1 with no homing pulses
    cyc(1);
    check("busy_n1", busy, 1);
    cyc(0);
    check("mode1", mode, 1);

    // SWEEP1: watch the flash-1 shifter swing to 256 and back
    mx = 0;
    for (int i = 0; i < 30; i++) begin
      cyc(0);
      if (sh1 > mx) mx = sh1;
    end
    check("sh1_max", mx, 256);
    check("sh2_idle", sh2, 32);

    // return home from pos1 = 2
    ok = 0;
    for (int i = 0; i < 40 && !ok; i++) begin
      if (m_state == M_RUN && s1 == 128) ok = 1;
      else cyc(0);
    end
    check("to_pos2", ok, 1);
    cyc(1);
    cyc(0);
    cyc(0);
    check("home_sh1", sh1, 32);
    check("mode2", mode, 2);

    // SWEEP2: flash-2 reaches 4
    mn2 = 32;
    for (int i = 0; i < 30; i++) begin
      cyc(0);
      if (sh2 < mn2) mn2 = sh2;
    end
    check("sh2_min", mn2, 4);

    // mode_next on a tick cycle, then a second press inside HOME
    ok = 0;
    for (int i = 0; i < 40 && !ok; i++) begin
      if (m_state == M_RUN && m_ph == TD - 1 && s2 != 32) ok = 1;
      else cyc(0);
    end
    check("to_tick", ok, 1);
    cyc(1);
    check("tick_nostep", f2_shift_left, 0);
    cyc(1);
    ok = 0;
    for (int i = 0; i < 10 && !ok; i++) begin
      if (!busy) ok = 1;
      else cyc(0);
    end
    check("home_done", ok, 1);
    check("mode3", mode, 3);

    // BOTH: mirrored sweep
    for (int i = 0; i < 30; i++) cyc(0);

    // wrap to OFF: no pulses afterwards
    cyc(1);
    for (int i = 0; i < 6; i++) cyc(0);
    check("mode0", mode, 0);
    npulse = 0;
    for (int i = 0; i < 20; i++) begin
      cyc(0);
      if (f1_shift_left | f1_shift_right | f2_shift_left | f2_shift_right) npulse++;
    end
    check("off_pulses", npulse, 0);

    // async reset in the middle of HOME
    cyc(1);
    cyc(0);
    ok = 0;
    for (int i = 0; i < 40 && !ok; i++) begin
      if (m_state == M_RUN && s1 == 256) ok = 1;
      else cyc(0);
    end
    check("to_pos3", ok, 1);
    cyc(1);
    check("home_busy", busy, 1);
    #3;
    reset = 1'b0;
    #1;
    check("arst", 32'(obs()), 0);
    model_reset();
    @(posedge clk);
    #1;
    check("arst_hold", 32'(obs()), 0);
    reset = 1'b1;
    repeat (2) cyc(0);
    // positions were cleared: HOME lasts one cycle with no pulses
    cyc(1);
    cyc(0);
    check("post_rst_mode", mode, 1);
    for (int i = 0; i < 8; i++) cyc(0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
